iic_slave_regbank_ctrl: RTL and testbench

- System-clocked I2C slave controller that owns a bank of NREGS 8-bit configuration registers.
- A pointer byte selects the register; pointer auto-increments on each data byte.
- Arbitrates register writes between the I2C bus and a local host port.
- Replaces the SCL-clocked single-byte slave wherever multiple registers and a host-side write path are needed.

---
 rtl/iic_slave_regbank_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_iic_slave_regbank_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_slave_regbank_ctrl.sv
// iic_slave_regbank_ctrl
//   System-clocked I2C slave that owns NREGS 8-bit configuration registers.
//   The first data byte after a write address sets the register pointer. Each
//   further written byte lands in reg[ptr] and advances the pointer. Reads
//   stream reg[ptr], reg[ptr+1], ... while the master ACKs. The pointer wraps
//   from NREGS-1 to 0. A local host port can also write the bank. When both
//   sides write the same index in one cycle, the I2C write wins.
//
//   Optional build macro: IIC_SPIKE_FILTER_EN adds a 3-sample majority filter
//   on synchronized SCL/SDA. It suppresses 1-clk spikes and adds 2 clk of
//   latency.
//
// Ports
//   clk, rst         system clock (>= 16x SCL), synchronous active-high reset
//   iic_scl          raw SCL from pad
//   iic_sda_i        raw SDA from pad
//   iic_sda_oe       1 = pull SDA low, 0 = release (open drain)
//   slave_addr       7-bit device address
//   host_we          host write strobe
//   host_idx         host write index
//   host_wdata       host write data
//   reg_out          register bank, reg[i] on bits [8i+7:8i]
//   wr_strobe        1-cycle pulse on an I2C register write
//   wr_idx           index of that write
//   host_collision   1-cycle pulse when a host write is dropped
//   busy             slave addressed (ACKed address until STOP/START/NACK)
module iic_slave_regbank_ctrl #(
  parameter int NREGS = 8,
  parameter int PW    = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iic_scl,
  input  logic               iic_sda_i,
  output logic               iic_sda_oe,
  input  logic [6:0]         slave_addr,
  input  logic               host_we,
  input  logic [PW-1:0]      host_idx,
  input  logic [7:0]         host_wdata,
  output logic [NREGS*8-1:0] reg_out,
  output logic               wr_strobe,
  output logic [PW-1:0]      wr_idx,
  output logic               host_collision,
  output logic               busy
);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, ADDR_ACK, PTR, PTR_ACK,
    WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_e;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_c, sda_c;
  logic       scl_prev_q, sda_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], iic_scl};
      sda_sync_q <= {sda_sync_q[0], iic_sda_i};
    end
  end

`ifdef IIC_SPIKE_FILTER_EN
  logic [2:0] scl_win_q, sda_win_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_win_q <= '1;
      sda_win_q <= '1;
    end else begin
      scl_win_q <= {scl_win_q[1:0], scl_sync_q[1]};
      sda_win_q <= {sda_win_q[1:0], sda_sync_q[1]};
    end
  end

  always_comb begin
    scl_c = (scl_win_q[0] & scl_win_q[1]) | (scl_win_q[0] & scl_win_q[2]) |
            (scl_win_q[1] & scl_win_q[2]);
    sda_c = (sda_win_q[0] & sda_win_q[1]) | (sda_win_q[0] & sda_win_q[2]) |
            (sda_win_q[1] & sda_win_q[2]);
  end
`else
  assign scl_c = scl_sync_q[1];
  assign sda_c = sda_sync_q[1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_c;
      sda_prev_q <= sda_c;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  =  scl_c & ~scl_prev_q;
  assign scl_fall  = ~scl_c &  scl_prev_q;
  assign start_det =  scl_c &  scl_prev_q &  sda_prev_q & ~sda_c;
  assign stop_det  =  scl_c &  scl_prev_q & ~sda_prev_q &  sda_c;

  // ---------------------------------------------------------------------------
  // Protocol FSM
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          wr_go_q, wr_go_d;     // byte complete, commit next clk
  logic          ptr_inc_q, ptr_inc_d; // advance ptr one clk after commit
  logic          i2c_we;
  logic [7:0]    regs_q [NREGS];
  logic [7:0]    rd_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_go_q   <= 1'b0;
      ptr_inc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_go_q   <= wr_go_d;
      ptr_inc_q <= ptr_inc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_go_d   = 1'b0;
    ptr_inc_d = 1'b0;
    i2c_we    = 1'b0;
    rd_byte   = regs_q[ptr_q];

    if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = DEV_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      // Write commit and pointer advance run on the system clock.
      // SCL is far slower, so both finish before the ACK fall.
      if (wr_go_q) begin
        i2c_we    = 1'b1;
        ptr_inc_d = 1'b1;
      end
      if (ptr_inc_q) ptr_d = ptr_q + 1'b1;

      case (state_q)
        IDLE: sda_oe_d = 1'b0;

        DEV_ADDR: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = {shift_q[6:0], sda_c};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (shift_q[7:1] == slave_addr) begin
              state_d  = ADDR_ACK;
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (shift_q[0]) begin
              shift_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
              state_d  = RD_DATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = PTR;
            end
          end
        end

        PTR: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = {shift_q[6:0], sda_c};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            ptr_d    = shift_q[PW-1:0];
            sda_oe_d = 1'b1;
            state_d  = PTR_ACK;
          end
        end

        PTR_ACK, WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = WR_DATA;
          end
        end

        WR_DATA: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = {shift_q[6:0], sda_c};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) wr_go_d = 1'b1;
          end else if (scl_fall && bit_cnt_q == 4'd8 && !wr_go_q && !ptr_inc_q) begin
            sda_oe_d = 1'b1;
            state_d  = WR_ACK;
          end
        end

        RD_DATA: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
            state_d  = RD_ACK;
          end else if (scl_fall && bit_cnt_q != 4'd0) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end

        RD_ACK: begin
          // ptr advances on the ACK rise. The fall then loads the new byte.
          if (scl_rise) begin
            if (sda_c) begin
              state_d  = IGNORE;
              busy_d   = 1'b0;
              sda_oe_d = 1'b0;
            end else begin
              ptr_d = ptr_q + 1'b1;
            end
          end else if (scl_fall) begin
            shift_d   = rd_byte;
            sda_oe_d  = ~rd_byte[7];
            bit_cnt_d = '0;
            state_d   = RD_DATA;
          end
        end

        IGNORE: sda_oe_d = 1'b0;

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Register bank and host arbitration
  // ---------------------------------------------------------------------------
  logic          wr_strobe_q;
  logic [PW-1:0] wr_idx_q;
  logic          host_coll_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q      <= '{default: '0};
      wr_strobe_q <= 1'b0;
      wr_idx_q    <= '0;
      host_coll_q <= 1'b0;
    end else begin
      wr_strobe_q <= i2c_we;
      host_coll_q <= 1'b0;
      if (i2c_we) wr_idx_q <= ptr_q;
      if (host_we) begin
        if (i2c_we && host_idx == ptr_q) host_coll_q <= 1'b1;
        else                             regs_q[host_idx] <= host_wdata;
      end
      if (i2c_we) regs_q[ptr_q] <= shift_q;
    end
  end

  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < NREGS; i++) reg_out[8*i +: 8] = regs_q[i];
  end

  // Release SDA combinationally on reset so the bus is freed immediately
  assign iic_sda_oe     = sda_oe_q & ~rst;
  assign wr_strobe      = wr_strobe_q;
  assign wr_idx         = wr_idx_q;
  assign host_collision = host_coll_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_iic_slave_regbank_ctrl.sv
`timescale 1ns/1ps
module tb_iic_slave_regbank_ctrl;
  localparam int NREGS = 8;
  localparam int PW    = 3;
`ifdef IIC_SPIKE_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              iic_scl = 1'b1;
  logic              sda_m = 1'b1;
  logic              iic_sda_i;
  logic              iic_sda_oe;
  logic [6:0]        slave_addr = 7'h2A;
  logic              host_we = 1'b0;
  logic [PW-1:0]     host_idx = '0;
  logic [7:0]        host_wdata = '0;
  logic [NREGS*8-1:0] reg_out;
  logic              wr_strobe;
  logic [PW-1:0]     wr_idx;
  logic              host_collision;
  logic              busy;

  int checks = 0;
  int errors = 0;
  logic [63:0]   exp_regs = '0;
  logic          oe_any = 1'b0;
  logic          coll_obs = 1'b0;
  logic [PW-1:0] strobe_log[$];

  assign iic_sda_i = sda_m & ~iic_sda_oe;
  always #5 clk = ~clk;

  iic_slave_regbank_ctrl #(.NREGS(NREGS)) dut (
    .clk(clk), .rst(rst), .iic_scl(iic_scl), .iic_sda_i(iic_sda_i),
    .iic_sda_oe(iic_sda_oe), .slave_addr(slave_addr), .host_we(host_we),
    .host_idx(host_idx), .host_wdata(host_wdata), .reg_out(reg_out),
    .wr_strobe(wr_strobe), .wr_idx(wr_idx), .host_collision(host_collision),
    .busy(busy)
  );

  task automatic tick();
    @(negedge clk);
    if (iic_sda_oe) oe_any = 1'b1;
    if (wr_strobe) strobe_log.push_back(wr_idx);
  endtask

  task automatic clk_bit(input logic b, input logic hc, input logic [PW-1:0] hidx,
                         input logic [7:0] hdat, output logic s);
    sda_m = b;
    repeat (5) tick();
    iic_scl = 1'b1;
    s = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 4) s = iic_sda_i;
      if (hc && k == LAT - 1) begin
        host_we = 1'b1; host_idx = hidx; host_wdata = hdat;
      end
      if (hc && k == LAT) begin
        coll_obs = host_collision;
        host_we = 1'b0;
      end
    end
    iic_scl = 1'b0;
    repeat (5) tick();
  endtask

  task automatic write_byte(input logic [7:0] d, input logic hc, input logic [PW-1:0] hidx,
                            input logic [7:0] hdat, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], hc && (i == 0), hidx, hdat, s);
    clk_bit(1'b1, 1'b0, '0, '0, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, 1'b0, '0, '0, s);
      d[i] = s;
    end
    clk_bit(nack, 1'b0, '0, '0, s);
  endtask

  task automatic start_cond();
    sda_m = 1'b1; repeat (5) tick();
    iic_scl = 1'b1; repeat (5) tick();
    sda_m = 1'b0; repeat (5) tick();
    iic_scl = 1'b0; repeat (5) tick();
  endtask

  task automatic stop_cond();
    sda_m = 1'b0; repeat (5) tick();
    iic_scl = 1'b1; repeat (5) tick();
    sda_m = 1'b1; repeat (5) tick();
  endtask

  task automatic host_write(input logic [PW-1:0] idx, input logic [7:0] d);
    host_idx = idx; host_wdata = d; host_we = 1'b1;
    tick();
    host_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) tick();
    checks++; if (reg_out !== 64'h0) begin errors++; $display("FAIL reset_regs: got %h expected %h", reg_out, 64'h0); end
    checks++; if (iic_sda_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", iic_sda_oe); end
    checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", wr_strobe); end
    checks++; if (host_collision !== 1'b0) begin errors++; $display("FAIL reset_coll: got %b expected 0", host_collision); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_write();
    logic a, acks;
    strobe_log.delete();
    start_cond();
    write_byte(8'h54, 1'b0, '0, '0, a); acks = a;
    write_byte(8'h03, 1'b0, '0, '0, a); acks &= a;
    write_byte(8'h5A, 1'b0, '0, '0, a); acks &= a;
    write_byte(8'hC3, 1'b0, '0, '0, a); acks &= a;
    checks++; if (acks !== 1'b1) begin errors++; $display("FAIL write_acks: got %b expected 1", acks); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_hi: got %b expected 1", busy); end
    stop_cond();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_lo: got %b expected 0", busy); end
    exp_regs[8*3 +: 8] = 8'h5A;
    exp_regs[8*4 +: 8] = 8'hC3;
    checks++; if (reg_out !== exp_regs) begin errors++; $display("FAIL write_regs: got %h expected %h", reg_out, exp_regs); end
    checks++;
    if (strobe_log.size() != 2 || strobe_log[0] !== 3'd3 || strobe_log[1] !== 3'd4) begin
      errors++; $display("FAIL write_strobes: got %0d pulses expected 2 pulses idx 3,4", strobe_log.size());
    end
  endtask

  task automatic test_read_wrap();
    logic a, acks;
    logic [7:0] d;
    host_write(3'd7, 8'h11);
    host_write(3'd0, 8'h22);
    exp_regs[8*7 +: 8] = 8'h11;
    exp_regs[8*0 +: 8] = 8'h22;
    tick();
    checks++; if (reg_out !== exp_regs) begin errors++; $display("FAIL host_preload: got %h expected %h", reg_out, exp_regs); end
    start_cond();
    write_byte(8'h54, 1'b0, '0, '0, a); acks = a;
    write_byte(8'h07, 1'b0, '0, '0, a); acks &= a;
    start_cond();
    write_byte(8'h55, 1'b0, '0, '0, a); acks &= a;
    checks++; if (acks !== 1'b1) begin errors++; $display("FAIL read_acks: got %b expected 1", acks); end
    read_byte(1'b0, d);
    checks++; if (d !== 8'h11) begin errors++; $display("FAIL read_byte0: got %h expected 11", d); end
    read_byte(1'b1, d);
    checks++; if (d !== 8'h22) begin errors++; $display("FAIL read_byte1_wrap: got %h expected 22", d); end
    tick();
    checks++; if (iic_sda_oe !== 1'b0) begin errors++; $display("FAIL read_release: got %b expected 0", iic_sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_nack_busy: got %b expected 0", busy); end
    stop_cond();
  endtask

  task automatic test_wrong_addr();
    logic a;
    logic dummy;
    strobe_log.delete();
    oe_any = 1'b0;
    start_cond();
    write_byte(8'h56, 1'b0, '0, '0, a);
    write_byte(8'h03, 1'b0, '0, '0, dummy);
    write_byte(8'h77, 1'b0, '0, '0, dummy);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL wrong_addr_ack: got %b expected 0", a); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrong_addr_busy: got %b expected 0", busy); end
    stop_cond();
    checks++; if (oe_any !== 1'b0) begin errors++; $display("FAIL wrong_addr_oe: got %b expected 0", oe_any); end
    checks++; if (reg_out !== exp_regs) begin errors++; $display("FAIL wrong_addr_regs: got %h expected %h", reg_out, exp_regs); end
    checks++; if (strobe_log.size() != 0) begin errors++; $display("FAIL wrong_addr_strobe: got %0d expected 0", strobe_log.size()); end
  endtask

  task automatic test_collision();
    logic a, acks;
    strobe_log.delete();
    start_cond();
    write_byte(8'h54, 1'b0, '0, '0, a); acks = a;
    write_byte(8'h02, 1'b0, '0, '0, a); acks &= a;
    coll_obs = 1'b0;
    write_byte(8'h10, 1'b1, 3'd2, 8'hFF, a); acks &= a;
    checks++; if (coll_obs !== 1'b1) begin errors++; $display("FAIL coll_same_idx: got %b expected 1", coll_obs); end
    coll_obs = 1'b1;
    write_byte(8'h33, 1'b1, 3'd5, 8'hFF, a); acks &= a;
    checks++; if (coll_obs !== 1'b0) begin errors++; $display("FAIL coll_diff_idx: got %b expected 0", coll_obs); end
    stop_cond();
    exp_regs[8*2 +: 8] = 8'h10;
    exp_regs[8*3 +: 8] = 8'h33;
    exp_regs[8*5 +: 8] = 8'hFF;
    checks++; if (acks !== 1'b1) begin errors++; $display("FAIL coll_acks: got %b expected 1", acks); end
    checks++; if (reg_out !== exp_regs) begin errors++; $display("FAIL coll_regs: got %h expected %h", reg_out, exp_regs); end
    checks++;
    if (strobe_log.size() != 2 || strobe_log[0] !== 3'd2 || strobe_log[1] !== 3'd3) begin
      errors++; $display("FAIL coll_strobes: got %0d pulses expected 2 pulses idx 2,3", strobe_log.size());
    end
  endtask

  task automatic test_rst_mid();
    logic a, acks, s;
    logic [3:0] nib;
    start_cond();
    write_byte(8'h54, 1'b0, '0, '0, a); acks = a;
    write_byte(8'h04, 1'b0, '0, '0, a); acks &= a;
    start_cond();
    write_byte(8'h55, 1'b0, '0, '0, a); acks &= a;
    for (int i = 3; i >= 0; i--) begin
      clk_bit(1'b1, 1'b0, '0, '0, s);
      nib[i] = s;
    end
    checks++; if (nib !== 4'hC) begin errors++; $display("FAIL rst_mid_nibble: got %h expected c", nib); end
    sda_m = 1'b1; repeat (5) tick();
    iic_scl = 1'b1; repeat (5) tick();
    checks++; if (iic_sda_oe !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_oe: got %b expected 1", iic_sda_oe); end
    rst = 1'b1;
    #1;
    checks++; if (iic_sda_oe !== 1'b0) begin errors++; $display("FAIL rst_mid_oe: got %b expected 0", iic_sda_oe); end
    tick();
    checks++; if (reg_out !== 64'h0) begin errors++; $display("FAIL rst_mid_regs: got %h expected 0", reg_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    rst = 1'b0;
    exp_regs = '0;
    repeat (3) tick();
    start_cond();
    write_byte(8'h54, 1'b0, '0, '0, a); acks &= a;
    write_byte(8'h01, 1'b0, '0, '0, a); acks &= a;
    write_byte(8'hA5, 1'b0, '0, '0, a); acks &= a;
    stop_cond();
    exp_regs[8*1 +: 8] = 8'hA5;
    checks++; if (acks !== 1'b1) begin errors++; $display("FAIL rst_mid_acks: got %b expected 1", acks); end
    checks++; if (reg_out !== exp_regs) begin errors++; $display("FAIL rst_mid_rewrite: got %h expected %h", reg_out, exp_regs); end
  endtask

`ifdef IIC_SPIKE_FILTER_EN
  task automatic test_spike();
    logic a;
    oe_any = 1'b0;
    tick();
    sda_m = 1'b0;
    tick();
    sda_m = 1'b1;
    repeat (5) tick();
    iic_scl = 1'b0;
    repeat (5) tick();
    write_byte(8'h54, 1'b0, '0, '0, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL spike_ack: got %b expected 0", a); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL spike_busy: got %b expected 0", busy); end
    checks++; if (oe_any !== 1'b0) begin errors++; $display("FAIL spike_oe: got %b expected 0", oe_any); end
    stop_cond();
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read_wrap();
    test_wrong_addr();
    test_collision();
    test_rst_mid();
`ifdef IIC_SPIKE_FILTER_EN
    test_spike();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
